// File: rtl/event_ts_pkg.sv
// Shared types and constants for the event timestamper and its record buffer.
// Record fields are sized for the widest supported configuration; narrower
// instances zero-extend into them and the unused upper bits are trimmed away.
package event_ts_pkg;

  localparam int MAX_ID_W  = 8;
  localparam int MAX_TS_W  = 32;
  localparam int ERR_CNT_W = 16;

  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

  // One completed (or timed-out) interval.
  typedef struct packed {
    logic [MAX_ID_W-1:0] id;
    logic [MAX_TS_W-1:0] start_ts;
    logic [MAX_TS_W-1:0] end_ts;
    logic [MAX_TS_W-1:0] delta;
    logic                timeout;
  } ev_rec_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == ERR_CNT_MAX) ? v : v + ERR_CNT_W'(1);
  endfunction

endpackage

// File: rtl/ev_rec_fifo.sv
// Synchronous first-word-fall-through FIFO holding timestamp records.
// Latency: a push at edge N is visible on pop_dat_o right after edge N when empty.
// Backpressure: pushes while full and pops while empty are ignored; caller gates on full/empty.
module ev_rec_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] push_dat_i,
  input  logic         pop_i,
  output logic [W-1:0] pop_dat_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          push_ok;
  logic          pop_ok;

  assign full_o    = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o   = (cnt_q == '0);
  assign push_ok   = push_i && !full_o;
  assign pop_ok    = pop_i && !empty_o;
  assign pop_dat_o = mem_q[rd_ptr_q];

  // Storage array; contents are only observed while occupancy covers them, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

  // Pointers and occupancy; depth is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/event_timestamper_v2.sv
// Pairs start/end events per ID, timestamps them and emits interval records; optional timeout scan.
// Latency: record visible the cycle after the end (or timeout) edge when the output buffer is empty.
// Backpressure: end_ready drops while the record buffer is full; start_ready drops only on same-ID start/end collision.
module event_timestamper_v2
  import event_ts_pkg::*;
#(
  parameter int ID_W       = 3,
  parameter int TS_W       = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [ID_W-1:0]      start_id,
  input  logic                 end_valid,
  output logic                 end_ready,
  input  logic [ID_W-1:0]      end_id,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ID_W-1:0]      out_id,
  output logic [TS_W-1:0]      out_start_ts,
  output logic [TS_W-1:0]      out_end_ts,
  output logic [TS_W-1:0]      out_delta,
  output logic                 out_timeout,
  output logic [ERR_CNT_W-1:0] err_orphan_cnt,
  output logic [ERR_CNT_W-1:0] err_dstart_cnt
);

  localparam int               NUM_ID = 2**ID_W;
  localparam logic [TS_W-1:0]  TMO    = TS_W'(TIMEOUT);

  logic [TS_W-1:0]      cnt_q;
  logic [NUM_ID-1:0]    active_q;
  logic [TS_W-1:0]      start_ts_q [NUM_ID];
  logic [ID_W-1:0]      scan_q;
  logic [ERR_CNT_W-1:0] orphan_q;
  logic [ERR_CNT_W-1:0] dstart_q;

  logic      collide;
  logic      start_fire;
  logic      end_fire;
  logic      end_hit;
  logic [TS_W-1:0] scan_age;
  logic      scan_due;
  logic      scan_blocked;
  logic      retire;

  logic      fifo_full;
  logic      fifo_empty;
  logic      push;
  logic      pop;
  ev_rec_t   push_rec;
  ev_rec_t   pop_rec;
  logic      unused_rec;

  logic [ID_W-1:0] sel_id;
  logic [TS_W-1:0] sel_start;
  logic [TS_W-1:0] sel_delta;

  // Same-ID start and end in one cycle: the end is served first, the start waits.
  assign collide     = start_valid && end_valid && (start_id == end_id);
  assign start_ready = !collide;
  assign end_ready   = !fifo_full;
  assign start_fire  = start_valid && start_ready;
  assign end_fire    = end_valid && end_ready;
  assign end_hit     = end_fire && active_q[end_id];

  // Timeout scan looks at one ID per cycle and backs off whenever the buffer
  // or the handshakes already claim this cycle's push slot or the same ID.
  assign scan_age     = cnt_q - start_ts_q[scan_q];
  assign scan_due     = (TIMEOUT != 0) && active_q[scan_q] && (scan_age >= TMO);
  assign scan_blocked = fifo_full || end_hit
                     || (start_fire && (start_id == scan_q))
                     || (end_fire && (end_id == scan_q));
  assign retire       = scan_due && !scan_blocked;
  assign push         = end_hit || retire;

  // Build the record for whichever source owns the push slot; end handshakes take priority.
  always_comb begin
    sel_id            = end_hit ? end_id : scan_q;
    sel_start         = start_ts_q[sel_id];
    sel_delta         = cnt_q - sel_start;
    push_rec          = '0;
    push_rec.id       = MAX_ID_W'(sel_id);
    push_rec.start_ts = MAX_TS_W'(sel_start);
    push_rec.end_ts   = MAX_TS_W'(cnt_q);
    push_rec.delta    = MAX_TS_W'(sel_delta);
    push_rec.timeout  = !end_hit;
  end

  // Free-running timestamp counter.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_q + 1'b1;
  end

  // Round-robin scan pointer, advances every cycle whether or not it retires.
  always_ff @(posedge clk) begin
    if (rst) scan_q <= '0;
    else     scan_q <= scan_q + 1'b1;
  end

  // Per-ID table: start sets/refreshes, end or timeout clears; the three never hit the same ID together.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= '0;
      for (int i = 0; i < NUM_ID; i++) start_ts_q[i] <= '0;
    end else begin
      if (start_fire) begin
        active_q[start_id]   <= 1'b1;
        start_ts_q[start_id] <= cnt_q;
      end
      if (end_fire) active_q[end_id] <= 1'b0;
      if (retire)   active_q[scan_q] <= 1'b0;
    end
  end

  // Protocol error counters: restart of a live ID, end of an idle ID.
  always_ff @(posedge clk) begin
    if (rst) begin
      orphan_q <= '0;
      dstart_q <= '0;
    end else begin
      if (start_fire && active_q[start_id]) dstart_q <= sat_inc(dstart_q);
      if (end_fire && !active_q[end_id])    orphan_q <= sat_inc(orphan_q);
    end
  end

  assign err_orphan_cnt = orphan_q;
  assign err_dstart_cnt = dstart_q;

  ev_rec_fifo #(
    .W     ($bits(ev_rec_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .push_dat_i (push_rec),
    .pop_i      (pop),
    .pop_dat_o  (pop_rec),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;

  // Fields read as zero whenever no record is presented.
  assign out_id       = out_valid ? pop_rec.id[ID_W-1:0]       : '0;
  assign out_start_ts = out_valid ? pop_rec.start_ts[TS_W-1:0] : '0;
  assign out_end_ts   = out_valid ? pop_rec.end_ts[TS_W-1:0]   : '0;
  assign out_delta    = out_valid ? pop_rec.delta[TS_W-1:0]    : '0;
  assign out_timeout  = out_valid && pop_rec.timeout;

  // Upper record bits beyond the configured widths are zero by construction.
  assign unused_rec = ^pop_rec;

endmodule

// File: tb/tb_event_timestamper_v2.sv
// Directed self-checking bench for event_timestamper_v2 (ID_W=3, TS_W=8, depth 4, timeout 50).
module tb_event_timestamper_v2;

  localparam int ID_W = 3;
  localparam int TS_W = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            start_valid, start_ready;
  logic [ID_W-1:0] start_id;
  logic            end_valid, end_ready;
  logic [ID_W-1:0] end_id;
  logic            out_valid, out_ready;
  logic [ID_W-1:0] out_id;
  logic [TS_W-1:0] out_start_ts, out_end_ts, out_delta;
  logic            out_timeout;
  logic [15:0]     err_orphan_cnt, err_dstart_cnt;

  int checks = 0;
  int errors = 0;
  int tb_cnt = 0;

  always #5 clk = ~clk;

  event_timestamper_v2 #(
    .ID_W(3), .TS_W(8), .FIFO_DEPTH(4), .TIMEOUT(50)
  ) dut (
    .clk(clk), .rst(rst),
    .start_valid(start_valid), .start_ready(start_ready), .start_id(start_id),
    .end_valid(end_valid), .end_ready(end_ready), .end_id(end_id),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_id(out_id), .out_start_ts(out_start_ts), .out_end_ts(out_end_ts),
    .out_delta(out_delta), .out_timeout(out_timeout),
    .err_orphan_cnt(err_orphan_cnt), .err_dstart_cnt(err_dstart_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // tb_cnt tracks the DUT counter value that the next edge will sample.
  task automatic tick();
    @(posedge clk);
    tb_cnt = (tb_cnt + 1) % 256;
    #1;
  endtask

  task automatic wait_cnt(input int v);
    while (tb_cnt != v) tick();
  endtask

  task automatic do_start(input logic [ID_W-1:0] id);
    start_valid = 1'b1; start_id = id;
    tick();
    start_valid = 1'b0;
  endtask

  task automatic do_end(input logic [ID_W-1:0] id);
    end_valid = 1'b1; end_id = id;
    tick();
    end_valid = 1'b0;
  endtask

  task automatic pop();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic chk_rec(input string tag, input int id, input int s, input int e, input int d, input int to);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_id"}, out_id, id);
    chk({tag, "_start"}, out_start_ts, s);
    chk({tag, "_end"}, out_end_ts, e);
    chk({tag, "_delta"}, out_delta, d);
    chk({tag, "_tmo"}, out_timeout, to);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_id"}, out_id, 0);
    chk({tag, "_start"}, out_start_ts, 0);
    chk({tag, "_end"}, out_end_ts, 0);
    chk({tag, "_delta"}, out_delta, 0);
    chk({tag, "_tmo"}, out_timeout, 0);
    chk({tag, "_srdy"}, start_ready, 1);
    chk({tag, "_erdy"}, end_ready, 1);
    chk({tag, "_orphan"}, err_orphan_cnt, 0);
    chk({tag, "_dstart"}, err_dstart_cnt, 0);
  endtask

  initial begin
    int n;
    int stale;
    rst = 1'b1;
    start_valid = 1'b0; start_id = '0;
    end_valid = 1'b0; end_id = '0;
    out_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_idle("reset");
    rst = 1'b0;
    tb_cnt = 0;

    // Basic interval: start id3 at 10, end at 16
    wait_cnt(10); do_start(3);
    wait_cnt(16); do_end(3);
    chk_rec("basic", 3, 10, 16, 6, 0);
    pop();
    chk("basic_drained", out_valid, 0);

    // Counter wrap: start id1 at 250, end at 4
    wait_cnt(250); do_start(1);
    wait_cnt(4); do_end(1);
    chk_rec("wrap", 1, 250, 4, 10, 0);
    pop();

    // Same-ID start/end collision at 30
    wait_cnt(20); do_start(5);
    wait_cnt(30);
    start_valid = 1'b1; start_id = 3'd5;
    end_valid = 1'b1; end_id = 3'd5;
    #1;
    chk("coll_srdy", start_ready, 0);
    chk("coll_erdy", end_ready, 1);
    tick();
    end_valid = 1'b0;
    #1;
    chk("coll_srdy_next", start_ready, 1);
    chk_rec("coll", 5, 20, 30, 10, 0);
    tick();
    start_valid = 1'b0;
    pop();
    wait_cnt(35); do_end(5);
    chk_rec("coll_restart", 5, 31, 35, 4, 0);
    pop();
    chk("coll_orphan", err_orphan_cnt, 0);
    chk("coll_dstart", err_dstart_cnt, 0);

    // Different IDs in the same cycle: start id6, end id4 at 45
    wait_cnt(40); do_start(4);
    wait_cnt(45);
    start_valid = 1'b1; start_id = 3'd6;
    end_valid = 1'b1; end_id = 3'd4;
    #1;
    chk("diff_srdy", start_ready, 1);
    tick();
    start_valid = 1'b0; end_valid = 1'b0;
    chk_rec("diff", 4, 40, 45, 5, 0);
    pop();

    // Backpressure: four records fill the buffer, fifth end is held
    wait_cnt(50);
    do_start(0); do_start(1); do_start(2); do_start(3);
    do_end(6); do_end(0); do_end(1); do_end(2);
    chk("full_erdy", end_ready, 0);
    end_valid = 1'b1; end_id = 3'd3;
    for (int k = 0; k < 3; k++) begin
      chk_rec("stall", 6, 45, 54, 9, 0);
      chk("stall_erdy", end_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("drain_erdy", end_ready, 1);
    chk_rec("drain0", 0, 50, 55, 5, 0);
    tick();
    end_valid = 1'b0;
    chk_rec("drain1", 1, 51, 56, 5, 0);
    tick();
    chk_rec("drain2", 2, 52, 57, 5, 0);
    tick();
    chk_rec("drain3", 3, 53, 62, 9, 0);
    tick();
    out_ready = 1'b0;
    chk("drain_empty", out_valid, 0);

    // Timeout retirement of id2 started at 0
    wait_cnt(0); do_start(2);
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    chk("tmo_seen", out_valid, 1);
    chk("tmo_id", out_id, 2);
    chk("tmo_flag", out_timeout, 1);
    chk("tmo_start", out_start_ts, 0);
    chk("tmo_range", (out_delta >= 50 && out_delta <= 57), 1);
    chk("tmo_end", out_end_ts, (tb_cnt + 255) % 256);
    chk("tmo_delta", out_delta, (tb_cnt + 255) % 256);
    pop();
    do_end(2);
    chk("orphan_cnt", err_orphan_cnt, 1);
    chk("orphan_norec", out_valid, 0);
    do_start(4); do_start(4);
    chk("dstart_cnt", err_dstart_cnt, 1);

    // Reset with three queued records and two active IDs (4 and 7)
    do_start(0); do_start(1); do_start(6);
    do_end(0); do_end(1); do_end(6);
    do_start(7);
    chk("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    tick();
    chk_idle("mid_rst");
    rst = 1'b0;
    tb_cnt = 0;
    do_end(4);
    chk("post_rst_orphan", err_orphan_cnt, 1);
    chk("post_rst_norec", out_valid, 0);
    stale = 0;
    repeat (120) begin
      tick();
      if (out_valid) stale++;
    end
    chk("post_rst_stale", stale, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/event_timestamper_v2.md
EVENT_TIMESTAMPER_V2 -- requirements
Module: event_timestamper_v2

Interface
REQ-001 SHALL have parameter ID_W, default 3, meaning ID width (2**ID_W tracked IDs).
REQ-002 SHALL have parameter TS_W, default 16, meaning timestamp/counter width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning output record buffer depth (power of 2, >=2).
REQ-004 SHALL have parameter TIMEOUT, default 0, meaning the timeout threshold in cycles (0 = timeout disabled, must be < 2**TS_W).
REQ-005 SHALL have port clk  in  1  sole clock; all logic on posedge.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have ports start_valid/start_ready/start_id  in/out/in  1/1/ID_W  start-event handshake.
REQ-008 SHALL have ports end_valid/end_ready/end_id  in/out/in  1/1/ID_W  end-event handshake.
REQ-009 SHALL have ports out_valid/out_ready  out/in  1/1  result handshake.
REQ-010 SHALL have ports out_id/out_start_ts/out_end_ts/out_delta/out_timeout  out  ID_W/TS_W/TS_W/TS_W/1  result record.
REQ-011 SHALL have ports err_orphan_cnt/err_dstart_cnt  out  16/16  saturating error counters.

Function
REQ-012 SHALL run a free-running counter cnt_q, +1 per cycle, wrapping modulo 2**TS_W; an event's timestamp is the cnt_q value present at its handshake edge.
REQ-013 SHALL hold per-ID state: an active bit and start_ts.
REQ-014 Start handshake (valid&ready) SHALL set active[id]=1 and start_ts[id]=cnt_q; start_ready=1 except in the same-ID collision case of REQ-018.
REQ-015 Start on an already-active ID SHALL overwrite start_ts and increment err_dstart_cnt.
REQ-016 end_ready SHALL equal !fifo_full; an end handshake on an active ID SHALL clear active and enqueue {id,start_ts,cnt_q,delta,timeout=0}.
REQ-017 An end handshake on an inactive ID SHALL be consumed, enqueue nothing, and increment err_orphan_cnt.
REQ-018 Same-cycle start and end with equal IDs: end wins, start_ready=0 that cycle, start accepted on a later cycle; different IDs: both accepted the same cycle.
REQ-019 delta SHALL be (end_ts - start_ts) mod 2**TS_W (single-wrap correct).
REQ-020 With TIMEOUT!=0, a scan pointer SHALL visit one ID per cycle, round-robin; if that ID is active and (cnt_q - start_ts) >= TIMEOUT, it SHALL clear the ID and enqueue {id,start_ts,cnt_q,delta,timeout=1}.
REQ-021 Scan retirement SHALL be skipped (pointer still advances) when the FIFO is full, an end is enqueuing that cycle, or a start/end handshake targets the scanned ID.
REQ-022 Output SHALL be first-word-fall-through: a record enqueued at edge N is visible with out_valid=1 after edge N when the FIFO was empty; records leave in enqueue order; a record is popped on out_valid&out_ready.
REQ-023 Output fields SHALL hold stable while out_valid=1 and out_ready=0.
REQ-024 Simultaneous pop and push at full SHALL not be allowed (end_ready=0 when full), occupancy never exceeds FIFO_DEPTH.
REQ-025 Error counters SHALL saturate at 16'hFFFF.

Reset
REQ-026 On rst=1 at a posedge: cnt_q=0, all IDs inactive, start_ts=0, FIFO empty, scan pointer=0, error counters=0.
REQ-027 During and after reset: out_valid=0, all out_* fields=0, start_ready=1, end_ready=1 (FIFO empty).
REQ-028 Reset mid-operation SHALL discard all pending records and active IDs; no record appears afterwards from pre-reset events.

Structure
REQ-029 A shared package event_ts_pkg SHALL hold the record struct type (id, start_ts, end_ts, delta, timeout), parameterised through localparams/width constants, and the error-counter width constant.
REQ-030 The output buffer SHALL be a separate sub-module ev_rec_fifo (sync FIFO, FWFT, full/empty).
REQ-031 ID table and scan/arbitration logic SHALL live in event_timestamper_v2.

Verification (ID_W=3, TS_W=8, FIFO_DEPTH=4, TIMEOUT=50 unless stated)
REQ-032 Start id3 at cnt=10, end id3 at cnt=16 -> next cycle out id3 start10 end16 delta6 timeout0.
REQ-033 Start id1 at cnt=250, end id1 at cnt=4 -> delta=10 (wrap).
REQ-034 id5 active from cnt=20; start5 and end5 both valid at cnt=30 -> record delta10, start_ready=0 that cycle, start accepted at cnt=31 with start_ts=31.
REQ-035 out_ready=0, five ends on active IDs -> end_ready=0 after 4th; 5th held; on out_ready=1 all five records emerge in order, fields stable while stalled.
REQ-036 Start id2 at cnt=0, no end -> record id2 timeout=1 delta in [50,57]; later end id2 -> err_orphan_cnt=1, no record; second start on active id -> err_dstart_cnt=1.
REQ-037 Reset asserted with 3 records queued and 2 IDs active -> out_valid=0 after that edge, counters 0, no stale records later.
